// File: rtl/clock_monitor.sv
// clock_monitor: measures period and high time of mon_clk in clk cycles,
// declares lock after LOCK_CNT in-tolerance periods and flags loss on timeout.
module clock_monitor #(
    parameter int EXP_PERIOD = 10,
    parameter int TOL        = 1,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 1000,
    parameter int W          = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mon_clk,
    input  logic         meas_en,
    output logic [W-1:0] period_cnt,
    output logic [W-1:0] high_cnt,
    output logic         meas_valid,
    output logic         locked,
    output logic         lost
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [W-1:0]  LO     = W'((EXP_PERIOD > TOL) ? EXP_PERIOD - TOL : 0);
    localparam logic [W-1:0]  HI     = W'(EXP_PERIOD + TOL);
    localparam logic [W-1:0]  TO     = W'(TIMEOUT);
    localparam logic [GW-1:0] LOCK_G = GW'(LOCK_CNT);

    typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE} state_t;

    state_t        state, state_n;
    logic          s1, s2, s3;
    logic          rise, fall, in_tol, timeout, active, meas;
    logic [W-1:0]  cnt, hlat;
    logic [GW-1:0] good, good_nx;

    assign rise    = s2 & ~s3;
    assign fall    = ~s2 & s3;
    assign active  = meas_en && state != IDLE;
    assign meas    = active && state == MEASURE && rise;
    assign in_tol  = cnt >= LO && cnt <= HI;
    // rise takes priority over a coincident timeout
    assign timeout = active && !rise && cnt >= TO;
    assign good_nx = (good == LOCK_G) ? good : good + 1'b1;

    always_comb begin
        state_n = !meas_en        ? IDLE :
                  state == IDLE   ? WAIT_EDGE :
                  timeout         ? WAIT_EDGE :
                  rise            ? MEASURE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            cnt        <= '0;
            hlat       <= '0;
            good       <= '0;
            period_cnt <= '0;
            high_cnt   <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            lost       <= 1'b0;
        end else begin
            s1         <= mon_clk;
            s2         <= s1;
            s3         <= s2;
            meas_valid <= meas;
            if (!active) begin
                cnt    <= '0;
                good   <= '0;
                locked <= 1'b0;
                lost   <= 1'b0;
            end else begin
                cnt <= rise ? W'(1) : (&cnt ? cnt : cnt + 1'b1);
                if (state == MEASURE && fall)
                    hlat <= cnt;
                if (rise)
                    lost <= 1'b0;
                if (timeout) begin
                    lost   <= 1'b1;
                    locked <= 1'b0;
                    good   <= '0;
                end
                if (meas) begin
                    period_cnt <= cnt;
                    high_cnt   <= hlat;
                    good       <= in_tol ? good_nx : '0;
                    locked     <= in_tol && (locked || good_nx == LOCK_G);
                end
            end
        end
    end
endmodule

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor: drives mon_clk period by period and checks every
// measurement against a per-period lock/tolerance model.
module tb_clock_monitor;
    logic        clk = 1'b0, rst_n = 1'b0, mon_clk = 1'b0, meas_en = 1'b0;
    logic [15:0] period_cnt, high_cnt;
    logic        meas_valid, locked, lost;

    clock_monitor dut (
        .clk(clk), .rst_n(rst_n), .mon_clk(mon_clk), .meas_en(meas_en),
        .period_cnt(period_cnt), .high_cnt(high_cnt),
        .meas_valid(meas_valid), .locked(locked), .lost(lost)
    );

    always #5 clk = ~clk;

    typedef struct {int p; int h; int lk;} meas_t;
    meas_t got_q[$], exp_q[$];
    int n_cmp = 0, n_bad = 0;
    int good = 0, prev_p = 0, prev_h = 0, last_p = 0, last_h = 0;
    bit armed = 0, prev_v = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    initial forever begin
        meas_t m;
        @(posedge clk);
        #1;
        if (meas_valid) begin
            m.p = int'(period_cnt);
            m.h = int'(high_cnt);
            m.lk = int'(locked);
            got_q.push_back(m);
            chk("vwidth", int'(prev_v), 0);
        end
        prev_v = meas_valid;
    end

    // A rise closes the previous period; the first rise after arming only opens one.
    task automatic model_rise(input int p, input int h);
        meas_t e;
        if (armed) begin
            good = (prev_p >= 9 && prev_p <= 11) ? good + 1 : 0;
            e.p = prev_p;
            e.h = prev_h;
            e.lk = (good >= 4) ? 1 : 0;
            exp_q.push_back(e);
            last_p = prev_p;
            last_h = prev_h;
        end
        armed = 1;
        prev_p = p;
        prev_h = h;
    endtask

    task automatic model_disarm();
        armed = 0;
        good = 0;
    endtask

    task automatic sync_check();
        meas_t g, e;
        chk("nmeas", got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk("period", g.p, e.p);
            chk("high", g.h, e.h);
            chk("locked", g.lk, e.lk);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Called at a negedge; returns at the negedge where the next period would start.
    task automatic drive(input int p, input int h, input bit en);
        if (en) model_rise(p, h);
        mon_clk = 1'b1;
        repeat (h) @(negedge clk);
        mon_clk = 1'b0;
        repeat (p - h) @(negedge clk);
        sync_check();
    endtask

    initial begin
        int p, h;
        #2;
        chk("rst_period", int'(period_cnt), 0);
        chk("rst_high", int'(high_cnt), 0);
        chk("rst_valid", int'(meas_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_lost", int'(lost), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        meas_en = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) drive(10, 5, 1);
        chk("nom_locked", int'(locked), 1);
        for (int i = 0; i < 3; i++) drive(10, 3, 1);
        for (int i = 0; i < 3; i++) drive(10, 7, 1);
        drive(11, 5, 1);
        drive(10, 5, 1);
        chk("tol11_locked", int'(locked), 1);
        drive(12, 6, 1);
        for (int i = 0; i < 5; i++) drive(10, 5, 1);
        drive(8, 4, 1);
        drive(9, 4, 1);

        for (int i = 0; i < 40; i++) begin
            p = $urandom_range(13, 8);
            h = $urandom_range(p - 2, 2);
            drive(p, h, 1);
        end
        for (int i = 0; i < 5; i++) drive(10, 5, 1);

        drive(10, 5, 1);
        repeat (985) @(negedge clk);
        chk("pre_lost", int'(lost), 0);
        repeat (15) @(negedge clk);
        chk("lost", int'(lost), 1);
        chk("lost_locked", int'(locked), 0);
        model_disarm();
        sync_check();
        drive(10, 5, 1);
        chk("lost_clear", int'(lost), 0);
        for (int i = 0; i < 5; i++) drive(10, 5, 1);
        chk("relock", int'(locked), 1);

        mon_clk = 1'b1;
        @(negedge clk);
        meas_en = 1'b0;
        model_disarm();
        repeat (2) @(negedge clk);
        chk("abort_locked", int'(locked), 0);
        chk("abort_lost", int'(lost), 0);
        chk("abort_period", int'(period_cnt), last_p);
        chk("abort_high", int'(high_cnt), last_h);
        repeat (2) @(negedge clk);
        mon_clk = 1'b0;
        repeat (5) @(negedge clk);
        drive(10, 5, 0);
        drive(10, 5, 0);
        chk("idle_period", int'(period_cnt), last_p);
        meas_en = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) drive(10, 4, 1);

        mon_clk = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_period", int'(period_cnt), 0);
        chk("arst_high", int'(high_cnt), 0);
        chk("arst_valid", int'(meas_valid), 0);
        chk("arst_locked", int'(locked), 0);
        chk("arst_lost", int'(lost), 0);
        mon_clk = 1'b0;
        model_disarm();
        got_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        drive(10, 5, 1);
        drive(10, 5, 1);
        for (int i = 0; i < 4; i++) drive(10, 5, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/clock_monitor.md
# clock_monitor

Measures the clock produced by the testbench clock generator (its `clk` output, wired here as `mon_clk`) against the system clock. Reports period and high time in system-clock cycles, declares lock after a run of in-tolerance periods, and flags loss of clock on timeout. Sits directly downstream of the clock generator and feeds self-checking benches and status logic.

## Interface
- `EXP_PERIOD`, 10: expected `mon_clk` period, in `clk` cycles.
- `TOL`, 1: allowed period deviation, in `clk` cycles (inclusive).
- `LOCK_CNT`, 4: consecutive in-tolerance periods required for lock.
- `TIMEOUT`, 1000: `clk` cycles without a rising edge before loss is declared.
- `W`, 16: counter and output width.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `mon_clk`  in  1  monitored clock; asynchronous to `clk`.
- `meas_en`  in  1  measurement enable; low forces IDLE.
- `period_cnt`  out  W  last measured period, in `clk` cycles.
- `high_cnt`  out  W  last measured high time, in `clk` cycles.
- `meas_valid`  out  1  one-cycle pulse when `period_cnt`/`high_cnt` update.
- `locked`  out  1  frequency within tolerance for ≥ `LOCK_CNT` consecutive periods.
- `lost`  out  1  no rising edge for `TIMEOUT` cycles.

## Operation
- Input conditioning:
  - 2-flop synchronizer `s1`→`s2`, plus a history flop `s3`.
  - `rise = s2 & ~s3`; `fall = ~s2 & s3`.
- Cycle counter `cnt` (W bits) saturates at all-ones.
  - On `rise`: `cnt <= 1`.
  - Otherwise: `cnt <= cnt + 1`.
  - Effect: the cycle k after a rise sees `cnt == k`.
- On `fall` in MEASURE: `hlat <= cnt`.
- FSM states:
  - IDLE:
    - Counters cleared; `locked = 0`, `lost = 0`.
    - `period_cnt`/`high_cnt` hold their last values.
    - `meas_en` high → WAIT_EDGE.
  - WAIT_EDGE:
    - Falls are ignored.
    - First `rise`: `cnt <= 1`, then → MEASURE. No `meas_valid`.
  - MEASURE, on each `rise`:
    - `period_cnt <= cnt`, `high_cnt <= hlat`, `meas_valid <= 1`.
    - Evaluate tolerance on the new period.
- Tolerance test: in-tolerance iff `max(EXP_PERIOD-TOL,0) ≤ cnt ≤ EXP_PERIOD+TOL`. Unsigned compare, no wrap.
- Lock counter `good` saturates at `LOCK_CNT`.
  - In-tolerance: `good <= good + 1`.
  - Out of tolerance: `good <= 0` and `locked <= 0`.
  - `locked <= 1` on the measurement where `good` reaches `LOCK_CNT`.
- Timeout:
  - Applies in WAIT_EDGE or MEASURE with no `rise`.
  - When `cnt` reaches `TIMEOUT`: `lost <= 1`, `locked <= 0`, `good <= 0`, → WAIT_EDGE.
  - `lost` stays set until the next `rise` or until `meas_en` goes low.
  - The first rise after a loss emits no `meas_valid`.
- `meas_en` low, any state: → IDLE next cycle. Any in-flight measurement is discarded.
- Simultaneous `rise` and timeout in the same cycle: `rise` wins and timeout is not declared.
- Minimum measurable `mon_clk` phase is 2 `clk` cycles. Faster input gives undefined counts, but the block must never hang; timeout and `meas_en` remain effective.

## Timing
- Reset values:
  - `period_cnt = 0`, `high_cnt = 0`, `meas_valid = 0`, `locked = 0`, `lost = 0`.
  - FSM = IDLE; `s1`/`s2`/`s3` = 0.
- Latency, `mon_clk` rising edge to `rise`: 2–3 `clk` edges (synchronizer).
- `meas_valid`, `period_cnt`, `high_cnt` and `locked` all update on the `clk` edge after the `rise` cycle, in the same cycle.
- `meas_valid` is high for exactly one cycle per measured period.
- `lost` asserts on the edge after `cnt == TIMEOUT` is reached.
- Asynchronous reset mid-operation: all state returns to its reset value immediately. After reset, an enabled block starts from IDLE → WAIT_EDGE.

## Test plan
- Reset check: assert `rst_n = 0` mid-MEASURE → all outputs 0 at once; release with `meas_en = 1` → first `meas_valid` on the second rise after release.
- Nominal lock: `clk` at 100 MHz, `mon_clk` at 10 MHz, 50% duty → `period_cnt = 10`, `high_cnt = 5` each `meas_valid`; `locked` rises with the 4th `meas_valid`.
- Duty measurement: 10 MHz at 30% duty → `high_cnt = 3`, `period_cnt = 10`; at 70% duty → `high_cnt = 7`.
- Tolerance boundary: period 11 → lock holds; period 12 → `locked` drops on that `meas_valid`, and 4 more good periods are needed to relock.
- Loss: stop `mon_clk` (generator `enable` low) → `lost = 1` about 1000 cycles after the last rise, `locked = 0`; restart → first rise clears `lost`, no `meas_valid` on it.
- Enable abort: drop `meas_en` mid-period → IDLE next cycle, `locked`/`lost` = 0, outputs hold their last values, no `meas_valid`.
